// File: rtl/lcd_st_packet_arbiter.sv
// Two-input packet-locked round-robin arbiter for 64-bit Avalon-ST video streams,
// feeding a single registered output stage (ready latency 0 on every port).
module lcd_st_packet_arbiter #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               arb_enable,
  input  logic               err_clr,
  output logic               in0_ready,
  input  logic               in0_valid,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic               in0_startofpacket,
  input  logic               in0_endofpacket,
  input  logic [EMPTY_W-1:0] in0_empty,
  output logic               in1_ready,
  input  logic               in1_valid,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic               in1_startofpacket,
  input  logic               in1_endofpacket,
  input  logic [EMPTY_W-1:0] in1_empty,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic [1:0]         grant,
  output logic               err_no_sop,
  output logic               err_mid_sop,
  output logic [CNT_W-1:0]   pkt_cnt0,
  output logic [CNT_W-1:0]   pkt_cnt1
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state;
  logic               rr_last;
  logic               first_beat;
  logic               can_load;
  logic               acc;
  logic               owner;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_sop;
  logic               sel_eop;
  logic [EMPTY_W-1:0] sel_empty;

  // grant is all-zero outside LOCKED, so both readies stay low in IDLE
  assign can_load  = ~out_valid | out_ready;
  assign in0_ready = grant[0] & can_load;
  assign in1_ready = grant[1] & can_load;
  assign acc       = (in0_valid & in0_ready) | (in1_valid & in1_ready);
  assign owner     = grant[1];

  assign sel_data  = owner ? in1_data          : in0_data;
  assign sel_sop   = owner ? in1_startofpacket : in0_startofpacket;
  assign sel_eop   = owner ? in1_endofpacket   : in0_endofpacket;
  assign sel_empty = owner ? in1_empty         : in0_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      rr_last           <= 1'b1;
      first_beat        <= 1'b1;
      grant             <= 2'b00;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= '0;
      err_no_sop        <= 1'b0;
      err_mid_sop       <= 1'b0;
      pkt_cnt0          <= '0;
      pkt_cnt1          <= '0;
    end else begin
      // output register drains on its own, independent of the FSM state
      if (acc) begin
        out_valid         <= 1'b1;
        out_data          <= sel_data;
        out_startofpacket <= sel_sop;
        out_endofpacket   <= sel_eop;
        out_empty         <= sel_empty;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // a new error in the same cycle as err_clr must survive the clear
      err_no_sop  <= (acc & first_beat & ~sel_sop) | (err_no_sop & ~err_clr);
      err_mid_sop <= (acc & ~first_beat & sel_sop) | (err_mid_sop & ~err_clr);

      case (state)
        IDLE: begin
          if (arb_enable && (in0_valid || in1_valid)) begin
            state      <= LOCKED;
            first_beat <= 1'b1;
            // on a tie, the input that did not own the last packet wins
            if (in0_valid && (!in1_valid || rr_last)) grant <= 2'b01;
            else                                      grant <= 2'b10;
          end
        end
        LOCKED: begin
          if (acc) begin
            first_beat <= 1'b0;
            if (sel_eop) begin
              state   <= IDLE;
              grant   <= 2'b00;
              rr_last <= owner;
              if (owner) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
              else       pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_st_packet_arbiter.sv
// Bench for lcd_st_packet_arbiter: queue-driven sources, random/patterned sink,
// packet-level round-robin reference model and per-cycle protocol checks.
module tb_lcd_st_packet_arbiter;

  localparam int DATA_W  = 64;
  localparam int EMPTY_W = 3;
  localparam int CNT_W   = 16;
  localparam int SOP_B   = EMPTY_W + 1;
  localparam int EOP_B   = EMPTY_W;

  typedef logic [DATA_W+EMPTY_W+1:0] beat_t;  // {data, sop, eop, empty}

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               arb_enable = 1'b0;
  logic               err_clr = 1'b0;
  logic               in0_ready, in1_ready;
  logic               in0_valid = 1'b0, in1_valid = 1'b0;
  logic [DATA_W-1:0]  in0_data = '0, in1_data = '0;
  logic               in0_startofpacket = 1'b0, in1_startofpacket = 1'b0;
  logic               in0_endofpacket = 1'b0, in1_endofpacket = 1'b0;
  logic [EMPTY_W-1:0] in0_empty = '0, in1_empty = '0;
  logic               out_ready = 1'b0;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_startofpacket, out_endofpacket;
  logic [EMPTY_W-1:0] out_empty;
  logic [1:0]         grant;
  logic               err_no_sop, err_mid_sop;
  logic [CNT_W-1:0]   pkt_cnt0, pkt_cnt1;

  lcd_st_packet_arbiter #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .arb_enable(arb_enable), .err_clr(err_clr),
    .in0_ready(in0_ready), .in0_valid(in0_valid), .in0_data(in0_data),
    .in0_startofpacket(in0_startofpacket), .in0_endofpacket(in0_endofpacket), .in0_empty(in0_empty),
    .in1_ready(in1_ready), .in1_valid(in1_valid), .in1_data(in1_data),
    .in1_startofpacket(in1_startofpacket), .in1_endofpacket(in1_endofpacket), .in1_empty(in1_empty),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket), .out_empty(out_empty),
    .grant(grant), .err_no_sop(err_no_sop), .err_mid_sop(err_mid_sop),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    fails  = 0;
  beat_t q0[$], q1[$], obs[$], exp_q[$];
  bit    or_pat[$];
  int    or_pct = 100;
  bit    m_rr = 1'b1;
  logic [CNT_W-1:0] m_cnt0 = '0, m_cnt1 = '0;

  function automatic beat_t mk(input logic [DATA_W-1:0] d, input bit s, input bit e,
                               input logic [EMPTY_W-1:0] em);
    return {d, s, e, em};
  endfunction

  function automatic beat_t cur_out();
    return {out_data, out_startofpacket, out_endofpacket, out_empty};
  endfunction

  function automatic logic [DATA_W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: whole packets leave in round-robin order, ties go to the input
  // that did not own the previous packet. Valid while every packet is queued up-front.
  task automatic build_exp();
    beat_t c0[$], c1[$], b;
    bit pick, done;
    c0 = q0; c1 = q1;
    while (c0.size() > 0 || c1.size() > 0) begin
      if (c0.size() > 0 && c1.size() > 0) pick = ~m_rr;
      else                                pick = (c1.size() > 0);
      m_rr = pick;
      do begin
        b = pick ? c1.pop_front() : c0.pop_front();
        exp_q.push_back(b);
        done = b[EOP_B];
      end while (!done);
      if (pick) m_cnt1 = m_cnt1 + 1'b1;
      else      m_cnt0 = m_cnt0 + 1'b1;
    end
  endtask

  // One clock, entered and left at a falling edge.
  task automatic tick();
    beat_t b, held, last_acc;
    bit a0, a1, stall;
    if (q0.size() > 0) begin
      b = q0[0]; in0_valid = 1'b1;
      {in0_data, in0_startofpacket, in0_endofpacket, in0_empty} = b;
    end else begin
      in0_valid = 1'b0; in0_data = rnd64();
      in0_startofpacket = 1'($urandom); in0_endofpacket = 1'($urandom); in0_empty = 3'($urandom);
    end
    if (q1.size() > 0) begin
      b = q1[0]; in1_valid = 1'b1;
      {in1_data, in1_startofpacket, in1_endofpacket, in1_empty} = b;
    end else begin
      in1_valid = 1'b0; in1_data = rnd64();
      in1_startofpacket = 1'($urandom); in1_endofpacket = 1'($urandom); in1_empty = 3'($urandom);
    end
    if (or_pat.size() > 0) out_ready = or_pat.pop_front();
    else                   out_ready = ($urandom_range(99) < or_pct);
    #1;
    a0 = in0_valid && in0_ready;
    a1 = in1_valid && in1_ready;
    if (out_valid && out_ready) obs.push_back(cur_out());
    stall = out_valid && !out_ready;
    held  = cur_out();
    last_acc = '0;
    if (stall) begin
      checks++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_ready: in0_ready=%b in1_ready=%b, required 0 0", in0_ready, in1_ready);
      end
    end
    @(posedge clk);
    if (a0) last_acc = q0.pop_front();
    if (a1) last_acc = q1.pop_front();
    @(negedge clk);
    if (a0 || a1) begin
      checks++;
      if (out_valid !== 1'b1 || cur_out() !== last_acc) begin
        fails++;
        $display("FAIL accept_latency: out_valid=%b beat=%h, required 1 %h", out_valid, cur_out(), last_acc);
      end
    end else if (stall) begin
      checks++;
      if (out_valid !== 1'b1 || cur_out() !== held) begin
        fails++;
        $display("FAIL output_hold: out_valid=%b beat=%h, required 1 %h", out_valid, cur_out(), held);
      end
    end
  endtask

  task automatic drain(input int budget, output bit ok);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    ok = !(q0.size() > 0 || q1.size() > 0 || out_valid);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q0.delete(); q1.delete(); obs.delete(); exp_q.delete(); or_pat.delete();
    m_rr = 1'b1; m_cnt0 = '0; m_cnt1 = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b, required 00", grant); end
    checks++;
    if (pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin
      fails++; $display("FAIL reset_counters: got %0d %0d, required 0 0", pkt_cnt0, pkt_cnt1);
    end
    checks++;
    if (err_no_sop !== 1'b0 || err_mid_sop !== 1'b0) begin
      fails++; $display("FAIL reset_errors: got %b %b, required 0 0", err_no_sop, err_mid_sop);
    end
    checks++;
    if (out_data !== '0 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_data_ready: data=%h rdy=%b%b, required 0 00", out_data, in0_ready, in1_ready);
    end
  endtask

  task automatic test_single();
    bit ok;
    obs.delete(); exp_q.delete();
    arb_enable = 1'b1; or_pct = 100;
    for (int k = 0; k < 4; k++)
      q0.push_back(mk(64'h1000_0000_0000_0000 + 64'(k), k == 0, k == 3, 3'd0));
    build_exp();
    tick();
    checks++;
    if (grant !== 2'b01) begin fails++; $display("FAIL single_grant: got %b, required 01", grant); end
    drain(100, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL single_drain: timed out, required drained"); end
    checks++;
    if (obs.size() !== exp_q.size()) begin
      fails++; $display("FAIL single_count: got %0d beats, required %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL single_beat%0d: got %h, required %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (grant !== 2'b00 || pkt_cnt0 !== m_cnt0) begin
      fails++; $display("FAIL single_end: grant=%b cnt0=%0d, required 00 %0d", grant, pkt_cnt0, m_cnt0);
    end
  endtask

  task automatic test_contention();
    bit ok;
    apply_reset();
    arb_enable = 1'b1; or_pct = 100;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 2; k++) begin
        q0.push_back(mk(64'hA000 + 64'(p * 16 + k), k == 0, k == 1, 3'(k)));
        q1.push_back(mk(64'hB000 + 64'(p * 16 + k), k == 0, k == 1, 3'(k + 2)));
      end
    build_exp();
    tick();
    checks++;
    if (grant !== 2'b01) begin fails++; $display("FAIL contention_first_grant: got %b, required 01", grant); end
    drain(200, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL contention_drain: timed out, required drained"); end
    checks++;
    if (obs.size() !== exp_q.size()) begin
      fails++; $display("FAIL contention_count: got %0d beats, required %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL contention_beat%0d: got %h, required %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (pkt_cnt0 !== m_cnt0 || pkt_cnt1 !== m_cnt1) begin
      fails++; $display("FAIL contention_counters: got %0d %0d, required %0d %0d", pkt_cnt0, pkt_cnt1, m_cnt0, m_cnt1);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    obs.delete(); exp_q.delete();
    arb_enable = 1'b1; or_pct = 100;
    q1.push_back(mk(64'h0123456789ABCDEF, 1'b1, 1'b0, 3'd0));
    q1.push_back(mk(64'hFEDCBA9876543210, 1'b0, 1'b0, 3'd0));
    q1.push_back(mk(64'h0F0F0F0F0F0F0F0F, 1'b0, 1'b1, 3'd5));
    or_pat = '{1, 1, 0, 0, 1, 0, 0, 1};
    build_exp();
    drain(100, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL bp_drain: timed out, required drained"); end
    checks++;
    if (obs.size() !== exp_q.size()) begin
      fails++; $display("FAIL bp_count: got %0d beats, required %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL bp_beat%0d: got %h, required %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (pkt_cnt1 !== m_cnt1) begin fails++; $display("FAIL bp_cnt1: got %0d, required %0d", pkt_cnt1, m_cnt1); end
  endtask

  task automatic test_random();
    bit ok;
    int np0, np1, len;
    for (int it = 0; it < 4; it++) begin
      obs.delete(); exp_q.delete();
      arb_enable = 1'b1;
      or_pct = $urandom_range(40, 100);
      np0 = $urandom_range(0, 4);
      np1 = $urandom_range(1, 4);
      for (int p = 0; p < np0; p++) begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++)
          q0.push_back(mk(rnd64(), k == 0, k == len - 1, (k == len - 1) ? 3'($urandom) : 3'd0));
      end
      for (int p = 0; p < np1; p++) begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++)
          q1.push_back(mk(rnd64(), k == 0, k == len - 1, (k == len - 1) ? 3'($urandom) : 3'd0));
      end
      build_exp();
      drain(2000, ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL random%0d_drain: timed out, required drained", it); end
      checks++;
      if (obs.size() !== exp_q.size()) begin
        fails++; $display("FAIL random%0d_count: got %0d beats, required %0d", it, obs.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs.size()) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL random%0d_beat%0d: got %h, required %h", it, i, obs[i], exp_q[i]); end
      end
      checks++;
      if (pkt_cnt0 !== m_cnt0 || pkt_cnt1 !== m_cnt1) begin
        fails++; $display("FAIL random%0d_counters: got %0d %0d, required %0d %0d", it, pkt_cnt0, pkt_cnt1, m_cnt0, m_cnt1);
      end
      checks++;
      if (err_no_sop !== 1'b0 || err_mid_sop !== 1'b0) begin
        fails++; $display("FAIL random%0d_errors: got %b %b, required 0 0", it, err_no_sop, err_mid_sop);
      end
    end
  endtask

  task automatic test_errors();
    bit ok;
    obs.delete(); exp_q.delete();
    arb_enable = 1'b1; or_pct = 100;
    q0.push_back(mk(64'hE0, 1'b0, 1'b0, 3'd0));
    q0.push_back(mk(64'hE1, 1'b0, 1'b0, 3'd0));
    q0.push_back(mk(64'hE2, 1'b1, 1'b0, 3'd0));
    q0.push_back(mk(64'hE3, 1'b0, 1'b1, 3'd1));
    build_exp();
    drain(100, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL err_drain: timed out, required drained"); end
    checks++;
    if (err_no_sop !== 1'b1 || err_mid_sop !== 1'b1) begin
      fails++; $display("FAIL err_flags_set: got %b %b, required 1 1", err_no_sop, err_mid_sop);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_no_sop !== 1'b0 || err_mid_sop !== 1'b0) begin
      fails++; $display("FAIL err_flags_clear: got %b %b, required 0 0", err_no_sop, err_mid_sop);
    end
    // error raised while err_clr is held: the set must win on that cycle
    err_clr = 1'b1;
    q1.push_back(mk(64'hE4, 1'b0, 1'b1, 3'd2));
    build_exp();
    tick();
    tick();
    checks++;
    if (err_no_sop !== 1'b1) begin fails++; $display("FAIL err_set_wins: got %b, required 1", err_no_sop); end
    tick();
    checks++;
    if (err_no_sop !== 1'b0) begin fails++; $display("FAIL err_held_clear: got %b, required 0", err_no_sop); end
    err_clr = 1'b0;
    drain(100, ok);
    checks++;
    if (obs.size() !== exp_q.size()) begin
      fails++; $display("FAIL err_count: got %0d beats, required %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL err_beat%0d: got %h, required %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_arb_enable();
    bit ok;
    int n;
    obs.delete(); exp_q.delete();
    arb_enable = 1'b1; or_pct = 100;
    for (int k = 0; k < 4; k++)
      q0.push_back(mk(64'hC0 + 64'(k), k == 0, k == 3, 3'd0));
    exp_q = q0;
    tick();
    tick();
    arb_enable = 1'b0;
    q1.push_back(mk(64'hD0, 1'b1, 1'b0, 3'd0));
    q1.push_back(mk(64'hD1, 1'b0, 1'b1, 3'd3));
    foreach (q1[i]) exp_q.push_back(q1[i]);
    n = 0;
    while (q0.size() > 0 && n < 20) begin tick(); n++; end
    repeat (4) tick();
    checks++;
    if (grant !== 2'b00 || q1.size() !== 2) begin
      fails++; $display("FAIL arb_disabled_hold: grant=%b in1_left=%0d, required 00 2", grant, q1.size());
    end
    arb_enable = 1'b1;
    tick();
    checks++;
    if (grant !== 2'b10) begin fails++; $display("FAIL arb_reenable_grant: got %b, required 10", grant); end
    drain(100, ok);
    m_rr = 1'b1; m_cnt0 = m_cnt0 + 1'b1; m_cnt1 = m_cnt1 + 1'b1;
    checks++;
    if (obs.size() !== exp_q.size()) begin
      fails++; $display("FAIL arb_count: got %0d beats, required %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL arb_beat%0d: got %h, required %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (pkt_cnt0 !== m_cnt0 || pkt_cnt1 !== m_cnt1) begin
      fails++; $display("FAIL arb_counters: got %0d %0d, required %0d %0d", pkt_cnt0, pkt_cnt1, m_cnt0, m_cnt1);
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    obs.delete(); exp_q.delete();
    arb_enable = 1'b1; or_pct = 100;
    for (int k = 0; k < 3; k++)
      q0.push_back(mk(64'h5A00 + 64'(k), k == 0, k == 2, 3'd0));
    or_pat = '{1, 1, 0};
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b1 || grant !== 2'b01) begin
      fails++; $display("FAIL rstmid_pre: out_valid=%b grant=%b, required 1 01", out_valid, grant);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_startofpacket !== 1'b0 || out_endofpacket !== 1'b0 ||
        out_empty !== '0 || grant !== 2'b00 || in0_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_outputs: valid=%b data=%h grant=%b rdy=%b, required 0 0 00 0",
                        out_valid, out_data, grant, in0_ready);
    end
    checks++;
    if (pkt_cnt0 !== '0 || pkt_cnt1 !== '0 || err_no_sop !== 1'b0 || err_mid_sop !== 1'b0) begin
      fails++; $display("FAIL rstmid_state: cnt=%0d %0d err=%b %b, required 0 0 0 0",
                        pkt_cnt0, pkt_cnt1, err_no_sop, err_mid_sop);
    end
    @(negedge clk);
    apply_reset();
    arb_enable = 1'b1; or_pct = 100;
    for (int k = 0; k < 2; k++) begin
      q0.push_back(mk(64'h6600 + 64'(k), k == 0, k == 1, 3'd0));
      q1.push_back(mk(64'h7700 + 64'(k), k == 0, k == 1, 3'd0));
    end
    build_exp();
    tick();
    checks++;
    if (grant !== 2'b01) begin fails++; $display("FAIL rstmid_grant: got %b, required 01", grant); end
    drain(100, ok);
    checks++;
    if (obs.size() !== exp_q.size()) begin
      fails++; $display("FAIL rstmid_count: got %0d beats, required %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL rstmid_beat%0d: got %h, required %h", i, obs[i], exp_q[i]); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_random();
    test_errors();
    test_arb_enable();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_st_packet_arbiter.md
Name: lcd_st_packet_arbiter

Overview:
- Two-input, packet-locked, round-robin arbiter for 64-bit Avalon-ST video streams.
- Shares the single LCD pixel FIFO input between the SGDMA frame stream (in0) and an overlay/test-pattern source (in1).
- Sits between the sources and the SGDMA-to-FIFO timing adapter.
- Has one registered output stage with ready-latency-0 semantics on all ports.

Parameters:
DATA_W, 64, data beat width
EMPTY_W, 3, empty field width
CNT_W, 16, width of per-input packet counters

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
arb_enable  in  1  1 = new grants allowed; 0 = finish current packet then hold IDLE
err_clr  in  1  synchronous clear of sticky error flags
in0_ready  out  1  sink ready, input 0
in0_valid  in  1  source valid, input 0
in0_data  in  DATA_W  beat data, input 0
in0_startofpacket  in  1  SOP, input 0
in0_endofpacket  in  1  EOP, input 0
in0_empty  in  EMPTY_W  empty bytes, input 0
in1_ready / in1_valid / in1_data / in1_startofpacket / in1_endofpacket / in1_empty: same widths and meanings, input 1
out_ready  in  1  downstream ready
out_valid  out  1  registered valid
out_data  out  DATA_W  registered data
out_startofpacket  out  1  registered SOP
out_endofpacket  out  1  registered EOP
out_empty  out  EMPTY_W  registered empty
grant  out  2  one-hot current owner; 00 in IDLE
err_no_sop  out  1  sticky: first beat of a granted packet lacked SOP
err_mid_sop  out  1  sticky: SOP seen on a non-first beat
pkt_cnt0  out  CNT_W  EOPs forwarded from in0, wraps
pkt_cnt1  out  CNT_W  EOPs forwarded from in1, wraps

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, rr_last = 1 (in0 wins the first tie), first_beat = 1.
- FSM states: IDLE and LOCKED.
- IDLE:
  - If arb_enable=1 and any inX_valid=1, pick the requester: if only one is valid, take it; if both are valid, take the one not equal to rr_last.
  - Register the choice into grant, go to LOCKED next cycle, set first_beat=1.
  - No beat is accepted in IDLE; inX_ready=0.
- LOCKED:
  - inX_ready = grant[X] & (~out_valid | out_ready); the non-granted ready is 0.
  - Accept beat = inX_valid & inX_ready. On accept, load the output register with the beat and set out_valid=1.
  - If out_ready=1 and there is no accept, clear out_valid.
- Accept of an EOP beat:
  - Next state is IDLE, grant is cleared, rr_last = owner, pkt_cnt[owner] increments (wraps at 2^CNT_W).
  - Result: at least one IDLE cycle between packets; an EOP on the first beat (single-beat packet) is legal.
- Latency: input accept to out_valid is 1 cycle. Back-to-back beats stream at full rate while out_ready=1.
- Output hold rule: out_* are stable while out_valid=1 and out_ready=0.
- Errors:
  - Accepted first beat with SOP=0 sets err_no_sop; the beat is still forwarded unchanged.
  - Accepted non-first beat with SOP=1 sets err_mid_sop; forwarded unchanged, packet lock is not broken.
  - err_clr=1 clears both flags. If set and clear happen in the same cycle, set wins.
- arb_enable dropping in LOCKED does not abort the packet; the arbiter stays in IDLE afterward until arb_enable=1.
- Non-granted input asserting valid never affects output or counters.
- Output register drains independently of the FSM: a pending out_valid beat may complete while in IDLE.
- Async reset mid-packet: the in-flight output beat is dropped, counters and flags clear, and the next grant follows rr_last=1.

Test Plan:
- Single requester: in0 sends 4 beats (SOP on beat0, EOP on beat3, empty=0), out_ready=1 -> out_valid beats appear 1 cycle after each accept, grant=01 during the packet, pkt_cnt0=1, then grant=00.
- Contention: both valid from reset, each sends two 2-beat packets -> output order in0,in1,in0,in1; beats never interleave within a packet; pkt_cnt0=pkt_cnt1=2.
- Backpressure: out_ready toggling 1,0,0,1 during an in1 packet with data 0x0123456789ABCDEF -> out_data held stable while stalled, in1_ready=0 when out_valid=1 and out_ready=0, no beat lost or duplicated.
- Protocol errors: first beat without SOP -> err_no_sop=1; SOP on beat2 -> err_mid_sop=1; both forwarded; err_clr pulse -> both 0.
- arb_enable=0 asserted mid-packet on in0 -> packet completes through EOP; no new grant while in1_valid=1, until arb_enable=1, then grant=10.
- Reset asserted while LOCKED with out_valid=1 -> all outputs 0 immediately; after release, both valid gives grant=01.
